// File: rtl/ifu_inst_queue.sv
// Fetch-to-decode instruction queue: 4-wide in-order enqueue, 2-wide in-order issue, flush on redirect.
// Optional performance counters are compiled in when IFU_IQ_PERF_EN is defined.
module ifu_inst_queue #(
    parameter int DEPTH     = 16,
    parameter int DEQ_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ifu_instA_valid,
    output logic        ifu_instA_allowIn,
    input  logic [31:0] ifu_instA_data,
    input  logic        ifu_instB_valid,
    output logic        ifu_instB_allowIn,
    input  logic [31:0] ifu_instB_data,
    input  logic        ifu_instC_valid,
    output logic        ifu_instC_allowIn,
    input  logic [31:0] ifu_instC_data,
    input  logic        ifu_instD_valid,
    output logic        ifu_instD_allowIn,
    input  logic [31:0] ifu_instD_data,
    output logic        iq_inst0_valid,
    input  logic        iq_inst0_ready,
    output logic [31:0] iq_inst0_data,
    output logic        iq_inst1_valid,
    input  logic        iq_inst1_ready,
    output logic [31:0] iq_inst1_data
`ifdef IFU_IQ_PERF_EN
    ,
    output logic [31:0] perf_full_cycles,
    output logic [31:0] perf_deq_insts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic [31:0]      mem [DEPTH];

    logic             acc_a, acc_b, acc_c, acc_d;
    logic [2:0]       enq_n;
    logic             fire0, fire1;
    logic [1:0]       deq_n;

    // Handshake: a lane/slot transfers on a cycle where its valid and its
    // allowIn/ready are both high; allowIn and iq valids depend only on
    // registered count and flush, never on the partner's valid or ready.
    assign free = CNT_W'(DEPTH) - count;

    assign ifu_instA_allowIn = (free >= CNT_W'(1)) & ~flush;
    assign ifu_instB_allowIn = (free >= CNT_W'(2)) & ~flush;
    assign ifu_instC_allowIn = (free >= CNT_W'(3)) & ~flush;
    assign ifu_instD_allowIn = (free >= CNT_W'(4)) & ~flush;

    assign acc_a = ifu_instA_valid & ifu_instA_allowIn;
    assign acc_b = ifu_instB_valid & ifu_instB_allowIn;
    assign acc_c = ifu_instC_valid & ifu_instC_allowIn;
    assign acc_d = ifu_instD_valid & ifu_instD_allowIn;

    assign enq_n = {2'b00, acc_a} + {2'b00, acc_b} + {2'b00, acc_c} + {2'b00, acc_d};

    assign iq_inst0_valid = (count >= CNT_W'(1)) & ~flush;
    assign iq_inst1_valid = (count >= CNT_W'(2)) & ~flush;
    assign iq_inst0_data  = mem[rd_ptr];
    assign iq_inst1_data  = mem[rd_ptr + PTR_W'(1)];

    // inst1 may only leave together with inst0 to keep issue in order.
    assign fire0 = iq_inst0_valid & iq_inst0_ready;
    assign fire1 = fire0 & iq_inst1_valid & iq_inst1_ready;
    assign deq_n = {1'b0, fire0} + {1'b0, fire1};

    // Lanes are contiguous from A, so lane index equals slot offset.
    always_ff @(posedge clk) begin
        if (acc_a) mem[wr_ptr]               <= ifu_instA_data;
        if (acc_b) mem[wr_ptr + PTR_W'(1)]   <= ifu_instB_data;
        if (acc_c) mem[wr_ptr + PTR_W'(2)]   <= ifu_instC_data;
        if (acc_d) mem[wr_ptr + PTR_W'(3)]   <= ifu_instD_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_n);
            rd_ptr <= rd_ptr + PTR_W'(deq_n);
            count  <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

`ifdef IFU_IQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_full_cycles <= '0;
            perf_deq_insts   <= '0;
        end else begin
            if (count == CNT_W'(DEPTH)) perf_full_cycles <= perf_full_cycles + 32'd1;
            perf_deq_insts <= perf_deq_insts + 32'(deq_n);
        end
    end
`else
    // No performance counters in this build.
`endif

    a_lanes_contiguous : assert property (@(posedge clk) disable iff (!rst)
        !(ifu_instB_valid & ~ifu_instA_valid) &&
        !(ifu_instC_valid & ~ifu_instB_valid) &&
        !(ifu_instD_valid & ~ifu_instC_valid));

    a_count_range : assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_W'(DEPTH));

    a_deq_width : assert property (@(posedge clk) DEQ_WIDTH == 2);

endmodule
